// File: rtl/aurora_link_pkg.sv
// Shared definitions for the Aurora link bring-up controller.
//   - 3-bit state encodings, also exported on state_o for VIO readback
//   - bit positions inside the aurora_ctrl VIO byte
//   - max3(): sizes the shared state timer
package aurora_link_pkg;

    localparam logic [2:0] ST_PWRDN     = 3'd0;
    localparam logic [2:0] ST_GT_RST    = 3'd1;
    localparam logic [2:0] ST_CORE_RST  = 3'd2;
    localparam logic [2:0] ST_WAIT_LANE = 3'd3;
    localparam logic [2:0] ST_WAIT_CHAN = 3'd4;
    localparam logic [2:0] ST_UP        = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    localparam int CTRL_MANUAL = 0;
    localparam int CTRL_PD     = 1;
    localparam int CTRL_LB_LO  = 2;
    localparam int CTRL_LB_HI  = 4;
    localparam int CTRL_AUTO   = 5;
    localparam int CTRL_CLR    = 6;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/aurora_link_ctrl_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous level bits,
// with a rising-edge strobe taken one cycle after synchronisation.
// Ports:
//   clk   - destination clock
//   rst   - asynchronous active-high reset
//   din   - asynchronous input bits
//   dout  - synchronised levels
//   rise  - one-cycle strobe per bit on a synchronised 0->1, gated by EDGE_MASK
module ctrl_sync #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] EDGE_MASK = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign rise = EDGE_MASK & sync & ~prev;

endmodule

// File: rtl/aurora_link_ctrl.sv
// Aurora link bring-up / recovery sequencer.
// Ports:
//   user_clk     - Aurora user clock, all logic on rising edge
//   reset        - asynchronous active-high reset
//   aurora_ctrl  - async VIO byte: [0] manual resync, [1] power-down,
//                  [4:2] loopback, [5] auto-retry, [6] clear, [7] reserved
//   lane_up      - core lane status
//   channel_up   - core channel status
//   gt_reset     - GT reset to core
//   aurora_reset - core reset
//   power_down   - core power-down
//   loopback     - GT loopback select
//   link_up      - high while in UP
//   link_fail    - high while in FAIL
//   retry_cnt    - automatic retries consumed (saturates at 15)
//   state_o      - current state encoding
//
// state     | meaning
// PWRDN     | core powered down, all resets held
// GT_RST    | GT reset pulse, GT_RST_CYCLES long
// CORE_RST  | core reset only, CORE_RST_CYCLES long
// WAIT_LANE | waiting for lane_up, bounded by LINK_TIMEOUT
// WAIT_CHAN | waiting for channel_up, bounded by LINK_TIMEOUT
// UP        | link operational
// FAIL      | retries exhausted; wait for clear or manual resync
module aurora_link_ctrl
    import aurora_link_pkg::*;
#(
    parameter int GT_RST_CYCLES   = 16,
    parameter int CORE_RST_CYCLES = 64,
    parameter int LINK_TIMEOUT    = 65535,
    parameter int MAX_RETRY       = 7
) (
    input  logic       user_clk,
    input  logic       reset,
    input  logic [7:0] aurora_ctrl,
    input  logic       lane_up,
    input  logic       channel_up,
    output logic       gt_reset,
    output logic       aurora_reset,
    output logic       power_down,
    output logic [2:0] loopback,
    output logic       link_up,
    output logic       link_fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam int TIMER_W = $clog2(max3(LINK_TIMEOUT, CORE_RST_CYCLES, GT_RST_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] GT_LAST   = TIMER_W'(GT_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CORE_LAST = TIMER_W'(CORE_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LINK_LAST = TIMER_W'(LINK_TIMEOUT - 1);

    logic [7:0]         ctrl_lvl;
    logic [7:0]         ctrl_rise;
    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         retry_nx;
    logic [2:0]         lb_nx;
    logic               enter;
    logic               take_retry;
    logic               unused_ctrl;

    ctrl_sync #(
        .WIDTH     (8),
        .EDGE_MASK (8'h41)
    ) u_ctrl_sync (
        .clk  (user_clk),
        .rst  (reset),
        .din  (aurora_ctrl),
        .dout (ctrl_lvl),
        .rise (ctrl_rise)
    );

    assign unused_ctrl = ^{ctrl_rise[7], ctrl_rise[5:1], ctrl_lvl[7],
                           ctrl_lvl[CTRL_CLR], ctrl_lvl[CTRL_MANUAL]};

    always_comb begin
        state_nx   = state;
        retry_nx   = retry_cnt;
        lb_nx      = loopback;
        enter      = 1'b0;
        take_retry = 1'b0;
        if (ctrl_lvl[CTRL_PD]) begin
            if (state != ST_PWRDN) begin
                state_nx = ST_PWRDN;
                enter    = 1'b1;
            end
        end else if (ctrl_rise[CTRL_MANUAL] || ctrl_rise[CTRL_CLR]) begin
            // Also taken while already in GT_RST, which restarts its count.
            state_nx = ST_GT_RST;
            retry_nx = '0;
            enter    = 1'b1;
        end else if (ctrl_lvl[CTRL_LB_HI:CTRL_LB_LO] != loopback) begin
            lb_nx    = ctrl_lvl[CTRL_LB_HI:CTRL_LB_LO];
            state_nx = ST_GT_RST;
            enter    = 1'b1;
        end else begin
            case (state)
                ST_PWRDN: begin
                    state_nx = ST_GT_RST;
                    enter    = 1'b1;
                end
                ST_GT_RST: begin
                    if (timer == GT_LAST) begin
                        state_nx = ST_CORE_RST;
                        enter    = 1'b1;
                    end
                end
                ST_CORE_RST: begin
                    if (timer == CORE_LAST) begin
                        state_nx = ST_WAIT_LANE;
                        enter    = 1'b1;
                    end
                end
                ST_WAIT_LANE: begin
                    if (lane_up) begin
                        state_nx = ST_WAIT_CHAN;
                        enter    = 1'b1;
                    end else if (timer == LINK_LAST) begin
                        take_retry = 1'b1;
                    end
                end
                ST_WAIT_CHAN: begin
                    if (channel_up) begin
                        state_nx = ST_UP;
                        enter    = 1'b1;
                    end else if (timer == LINK_LAST) begin
                        take_retry = 1'b1;
                    end
                end
                ST_UP: begin
                    if (!channel_up) take_retry = 1'b1;
                end
                ST_FAIL: begin
                    state_nx = ST_FAIL;
                end
                default: begin
                    state_nx = ST_GT_RST;
                    enter    = 1'b1;
                end
            endcase
            if (take_retry) begin
                enter = 1'b1;
                if (ctrl_lvl[CTRL_AUTO] && (retry_cnt < 4'(MAX_RETRY))) begin
                    retry_nx = (retry_cnt == 4'hf) ? retry_cnt : retry_cnt + 4'd1;
                    state_nx = ST_GT_RST;
                end else begin
                    state_nx = ST_FAIL;
                end
            end
        end
    end

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_GT_RST;
            timer     <= '0;
            retry_cnt <= '0;
            loopback  <= '0;
        end else begin
            state     <= state_nx;
            timer     <= enter ? '0 : timer + 1'b1;
            retry_cnt <= retry_nx;
            loopback  <= lb_nx;
        end
    end

    // Control outputs follow the registered state, so they lag it by one cycle.
    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            gt_reset     <= 1'b1;
            aurora_reset <= 1'b1;
            power_down   <= 1'b0;
            link_up      <= 1'b0;
            link_fail    <= 1'b0;
        end else begin
            gt_reset     <= (state == ST_PWRDN) || (state == ST_GT_RST);
            aurora_reset <= (state == ST_PWRDN) || (state == ST_GT_RST) ||
                            (state == ST_CORE_RST) || (state == ST_FAIL);
            power_down   <= (state == ST_PWRDN);
            link_up      <= (state == ST_UP);
            link_fail    <= (state == ST_FAIL);
        end
    end

    assign state_o = state;

endmodule
